// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program/data memory bus arbiter.
package mem_arb_pkg;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    GNT_PROG,
    GNT_DATA
  } grant_e;

  // Latched memory command of the current winner.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Fixed priority: data wins any contention.
  function automatic grant_e pick_fixed(input logic d_req);
    return d_req ? GNT_DATA : GNT_PROG;
  endfunction

  // Alternating priority: on contention the requester not granted last wins.
  function automatic grant_e pick_rr(input logic p_req, input logic d_req, input grant_e last);
    if (p_req && d_req) begin
      return (last == GNT_PROG) ? GNT_DATA : GNT_PROG;
    end
    return d_req ? GNT_DATA : GNT_PROG;
  endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Down-counter for memory wait states: load, decrement, zero flag.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero_c
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates program-fetch and data ports onto one single-port memory.
// Build macro ARB_ROUND_ROBIN_EN selects alternating priority; otherwise data wins.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state;
  grant_e     winner;
  mem_cmd_t   cmd_q;
  mem_cmd_t   cmd_c;
  grant_e     next_grant_c;
  logic       cnt_load_c;
  logic       cnt_dec_c;
  logic       cnt_zero_c;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e last_grant;
  assign next_grant_c = pick_rr(p_req, d_req, last_grant);
`else
  assign next_grant_c = pick_fixed(d_req);
`endif

  // Command the winner would present if granted this cycle.
  always_comb begin
    cmd_c = '0;
    if (next_grant_c == GNT_DATA) begin
      cmd_c.we    = d_we;
      cmd_c.addr  = d_addr;
      cmd_c.wdata = d_wdata;
    end else begin
      cmd_c.addr  = p_addr;
    end
  end

  assign cnt_load_c = (state == ST_IDLE) && (p_req || d_req);
  assign cnt_dec_c  = (state == ST_ACCESS) && !cnt_zero_c;

  mem_arb_wait_cnt u_wait_cnt (
    .clk      (CLK),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val (WAIT_W'(WAIT_STATES)),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      winner    <= GNT_PROG;
      cmd_q     <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p_ack     <= 1'b0;
      d_ack     <= 1'b0;
      p_rdata   <= '0;
      d_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= GNT_PROG;
`endif
    end else begin
      p_ack  <= 1'b0;
      d_ack  <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (p_req || d_req) begin
            winner <= next_grant_c;
            cmd_q  <= cmd_c;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= next_grant_c;
`endif
            state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_cs    <= 1'b1;
          mem_we    <= cmd_q.we;
          mem_addr  <= cmd_q.addr;
          mem_wdata <= cmd_q.wdata;
          if (cnt_zero_c) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // mem_addr is still held, so read data is sampled as the select drops.
          if (winner == GNT_PROG) begin
            p_ack   <= 1'b1;
            p_rdata <= mem_rdata;
          end else begin
            d_ack <= 1'b1;
            if (!cmd_q.we) begin
              d_rdata <= mem_rdata;
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, extra memory cycles per access (0..15).
REQ-002 SHALL have port CLK  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port p_req  in  1  program-fetch request.
REQ-005 SHALL have port p_addr  in  32  fetch address.
REQ-006 SHALL have port p_rdata  out  32  fetched instruction.
REQ-007 SHALL have port p_ack  out  1  fetch complete, one-cycle pulse.
REQ-008 SHALL have port d_req  in  1  data request.
REQ-009 SHALL have port d_we  in  1  data write enable.
REQ-010 SHALL have port d_addr  in  32  data address.
REQ-011 SHALL have port d_wdata  in  32  write data.
REQ-012 SHALL have port d_rdata  out  32  read data.
REQ-013 SHALL have port d_ack  out  1  data complete, one-cycle pulse.
REQ-014 SHALL have ports mem_cs, mem_we (out 1), mem_addr, mem_wdata (out 32), and mem_rdata (in 32) for the shared single-port memory.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-016 IDLE: with any req high, SHALL select a winner, register addr/we/wdata, load wait counter with WAIT_STATES, and enter ACCESS at the next edge; no request -> remain in IDLE.
REQ-017 ACCESS SHALL last exactly WAIT_STATES+1 cycles with mem_cs=1, mem_addr/mem_wdata driven from registers, and mem_we=1 only for a data write.
REQ-018 On the last ACCESS edge, a read SHALL capture mem_rdata into the winner's rdata register; the other rdata register SHALL hold its value.
REQ-019 DONE SHALL last 1 cycle with mem_cs=0 and the winner's ack=1; the loser's ack SHALL stay 0.
REQ-020 Latency SHALL be: req sampled at edge N -> ack high in the cycle after edge N+WAIT_STATES+2.
REQ-021 A write SHALL pulse d_ack and leave d_rdata unchanged.
REQ-022 Requests SHALL be ignored in ACCESS and DONE; a req still high on returning to IDLE SHALL start a new access (back-to-back rate = one access per WAIT_STATES+3 cycles).
REQ-023 A req dropped mid-access SHALL NOT abort the access; ack still pulses.
REQ-024 Address/data changes on request inputs during ACCESS SHALL have no effect.
REQ-025 The memory port SHALL NOT be granted to both requesters at once.

Reset
REQ-026 reset SHALL, at the next edge and from any state, force IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, p_ack=0, d_ack=0, p_rdata=0, d_rdata=0, and last_grant=PROG.
REQ-027 An in-flight access SHALL be abandoned with no ack.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN: if defined, simultaneous requests SHALL be granted to the requester not granted last (last_grant register, updated on each grant); if undefined, data SHALL always win contention and last_grant SHALL be absent.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the FSM state enum, the grant enum (GNT_PROG, GNT_DATA), and the counter width constant WAIT_W=4.
REQ-030 The wait counter SHALL be a sub-module mem_arb_wait_cnt (load, decrement, zero flag).

Verification
REQ-031 Fetch only, p_addr=32'h064f, mem_rdata=32'h064f, WAIT_STATES=2 -> mem_cs high 3 cycles, p_ack pulses in 5th cycle after req sampled, p_rdata=32'h064f.
REQ-032 Data write, d_addr=32'h22b4, d_wdata=32'hA5A5A5A5 -> mem_we=1 during ACCESS with matching addr/wdata, d_ack pulses once, d_rdata unchanged.
REQ-033 p_req and d_req held high for 4 accesses -> without macro: 4 data grants; with ARB_ROUND_ROBIN_EN: grants D,P,D,P.
REQ-034 reset asserted in the 2nd ACCESS cycle -> next cycle IDLE, all outputs 0, no ack; access restarts after reset release while req is held.
REQ-035 WAIT_STATES=0, read -> mem_cs high 1 cycle, ack 2 cycles after req sampled; mem_rdata captured correctly.
